// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared types and constants for the dino player input path
//
// Purpose : debounce FSM state type and default debounce length used by
//           button_debounce and button_conditioner.
// Contents: debounce_state_t   LOW / CHK_HIGH / HIGH / CHK_LOW
//           DINO_DEBOUNCE_CYCLES  default agreement length (16)

package dino_pkg;

   typedef enum logic [1:0] {
      LOW      = 2'd0,
      CHK_HIGH = 2'd1,
      HIGH     = 2'd2,
      CHK_LOW  = 2'd3
   } debounce_state_t;

   localparam int DINO_DEBOUNCE_CYCLES = 16;

endpackage : dino_pkg

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchroniser plus 4-state debounce FSM for one button
//
// Purpose : brings one raw, bouncing, asynchronous button into the clk domain
//           and accepts a new level only after DEBOUNCE_CYCLES consecutive
//           synchronised cycles of agreement.
// Ports   : clk      in   system clock
//           reset_n  in   asynchronous active-low reset
//           raw      in   raw button, 1 = pressed
//           stable   out  debounced level (1 in HIGH and CHK_LOW)
//           rise     out  one-cycle pulse in the cycle the FSM moves
//                         CHK_HIGH -> HIGH; the stable level rises on the
//                         following edge
// Params  : DEBOUNCE_CYCLES  agreement length, >= 2

module button_debounce
   import dino_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DINO_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic stable,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic            sync_1;
   logic            sync_2;
   debounce_state_t state;
   debounce_state_t state_next;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic [CW-1:0]   count_inc;

   // Two-flop synchroniser; sync_1 may go metastable, only sync_2 is used.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= LOW;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // Saturating increment: the counter can never wrap back into the
   // "not yet agreed" range, whatever DEBOUNCE_CYCLES is.
   assign count_inc = (count >= CNT_MAX) ? CNT_MAX : count + CNT_ONE;

   // The count already holds the agreeing cycles seen so far, so the
   // transition happens on the cycle that would bring it to DEBOUNCE_CYCLES.
   always_comb begin
      state_next = state;
      count_next = count;
      rise       = 1'b0;
      case (state)
         LOW: begin
            if (sync_2) begin
               state_next = CHK_HIGH;
               count_next = CNT_ONE;
            end
         end
         CHK_HIGH: begin
            if (!sync_2) begin
               state_next = LOW;
               count_next = '0;
            end else if (count >= CNT_LAST) begin
               state_next = HIGH;
               count_next = '0;
               rise       = 1'b1;
            end else begin
               count_next = count_inc;
            end
         end
         HIGH: begin
            if (!sync_2) begin
               state_next = CHK_LOW;
               count_next = CNT_ONE;
            end
         end
         CHK_LOW: begin
            if (sync_2) begin
               state_next = HIGH;
               count_next = '0;
            end else if (count >= CNT_LAST) begin
               state_next = LOW;
               count_next = '0;
            end else begin
               count_next = count_inc;
            end
         end
         default: begin
            state_next = LOW;
            count_next = '0;
         end
      endcase
   end

   assign stable = (state == HIGH) || (state == CHK_LOW);

endmodule : button_debounce

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced up/down buttons for the dino player controller
//
// Purpose : debounces both raw buttons and drives button_up / button_down.
//           With BUTTON_UP_LATCH_EN defined, an accepted up press is held in
//           up_pending until a game_tick[0] cycle consumes it, so short
//           presses are not lost between controller ticks. Without it,
//           button_up is the plain debounced up level and game_tick is unused.
// Ports   : clk           in   system clock
//           reset_n       in   asynchronous active-low reset
//           game_tick     in   tick strobes; only bit 0 is used
//           btn_up_raw    in   raw up button, 1 = pressed
//           btn_down_raw  in   raw down button, 1 = pressed
//           button_up     out  up request to the controller
//           button_down   out  debounced down level
// Params  : DEBOUNCE_CYCLES  agreement length, >= 2
// Macro   : BUTTON_UP_LATCH_EN  enables the up_pending latch

module button_conditioner
   import dino_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DINO_DEBOUNCE_CYCLES
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] game_tick,
   input  logic       btn_up_raw,
   input  logic       btn_down_raw,
   output logic       button_up,
   output logic       button_down
);

   logic up_stable;
   logic up_rise;
   logic down_stable;
   logic down_rise;
   logic unused_bits;

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_up_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (btn_up_raw),
      .stable  (up_stable),
      .rise    (up_rise)
   );

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_down_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (btn_down_raw),
      .stable  (down_stable),
      .rise    (down_rise)
   );

   assign button_down = down_stable;

`ifdef BUTTON_UP_LATCH_EN
   logic up_pending;

   // A new press wins over a same-cycle tick so it is delivered at the
   // following tick. Release never clears the request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         up_pending <= 1'b0;
      end else if (up_rise) begin
         up_pending <= 1'b1;
      end else if (game_tick[0]) begin
         up_pending <= 1'b0;
      end
   end

   assign button_up   = up_pending;
   assign unused_bits = ^{game_tick[1], up_stable, down_rise};
`else
   assign button_up   = up_stable;
   assign unused_bits = ^{game_tick, up_rise, down_rise};
`endif

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized self-checking bench for button_conditioner

module tb_button_conditioner;

   localparam int DB = 4;

   logic       clk;
   logic       reset_n;
   logic [1:0] game_tick;
   logic       btn_up_raw;
   logic       btn_down_raw;
   logic       button_up;
   logic       button_down;

   int vectors;
   int miscompares;

   // Reference model: raw history, run length of disagreement with the
   // accepted level, accepted levels, pending up request.
   logic [1:0] m_hist_u;
   logic [1:0] m_hist_d;
   int         m_run_u;
   int         m_run_d;
   logic       m_stab_u;
   logic       m_stab_d;
   logic       m_pend;

   button_conditioner #(
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .game_tick    (game_tick),
      .btn_up_raw   (btn_up_raw),
      .btn_down_raw (btn_down_raw),
      .button_up    (button_up),
      .button_down  (button_down)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic got, input logic exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hist_u = '0;
      m_hist_d = '0;
      m_run_u  = 0;
      m_run_d  = 0;
      m_stab_u = 1'b0;
      m_stab_d = 1'b0;
      m_pend   = 1'b0;
   endtask

   // One rising edge: the debouncer sees the raw value from two edges back;
   // a level is accepted after DB consecutive disagreeing samples.
   task automatic model_edge(input logic up, input logic dn, input logic tick0);
      logic rise;
      rise = 1'b0;
      if (m_hist_u[1] != m_stab_u) m_run_u++; else m_run_u = 0;
      if (m_run_u == DB) begin
         m_stab_u = ~m_stab_u;
         m_run_u  = 0;
         rise     = m_stab_u;
      end
      if (m_hist_d[1] != m_stab_d) m_run_d++; else m_run_d = 0;
      if (m_run_d == DB) begin
         m_stab_d = ~m_stab_d;
         m_run_d  = 0;
      end
      if (rise) m_pend = 1'b1;
      else if (tick0) m_pend = 1'b0;
      m_hist_u = {m_hist_u[0], up};
      m_hist_d = {m_hist_d[0], dn};
   endtask

   function automatic logic model_up();
`ifdef BUTTON_UP_LATCH_EN
      return m_pend;
`else
      return m_stab_u;
`endif
   endfunction

   // Drive inputs for one cycle, take the edge, then compare against the model.
   task automatic step(input logic up, input logic dn, input logic [1:0] tk);
      btn_up_raw   = up;
      btn_down_raw = dn;
      game_tick    = tk;
      @(posedge clk);
      model_edge(up, dn, tk[0]);
      #1;
      check_value("model_up", button_up, model_up());
      check_value("model_down", button_down, m_stab_d);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must drop before any edge.
   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_value("rst_async_up", button_up, 1'b0);
      check_value("rst_async_down", button_down, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check_value("rst_hold_up", button_up, 1'b0);
         check_value("rst_hold_down", button_down, 1'b0);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      logic r_up;
      logic r_dn;
      logic exp;
      vectors     = 0;
      miscompares = 0;
      model_reset();

      // Reset with both raw inputs pressed.
      reset_n      = 1'b0;
      btn_up_raw   = 1'b1;
      btn_down_raw = 1'b1;
      game_tick    = 2'b00;
      #1;
      check_value("rst0_up", button_up, 1'b0);
      check_value("rst0_down", button_down, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
         check_value("rst_up", button_up, 1'b0);
         check_value("rst_down", button_down, 1'b0);
      end
      btn_up_raw   = 1'b0;
      btn_down_raw = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // Down held 20 cycles: rises at edge 6, falls 6 edges after release.
      for (int k = 1; k <= 30; k++) begin
         step(1'b0, k <= 20, 2'b00);
         exp = (k >= 6) && (k < 26);
         check_value("down_latency", button_down, exp);
      end

      // Up glitch of 3 cycles with regular ticks: never accepted.
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         step(k <= 3, 1'b0, (k % 8 == 0) ? 2'b01 : 2'b00);
         check_value("glitch_up", button_up, 1'b0);
      end

      // Up held 10 cycles, single tick at cycle 40.
      do_reset();
      for (int k = 1; k <= 48; k++) begin
         step(k <= 10, 1'b0, (k == 40) ? 2'b01 : 2'b00);
`ifdef BUTTON_UP_LATCH_EN
         exp = (k >= 6) && (k < 40);
`else
         exp = (k >= 6) && (k < 16);
`endif
         check_value("up_hold", button_up, exp);
      end

      // Stable rise coincides with a tick; next tick at cycle 14.
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         step(1'b1, 1'b0, (k == 6 || k == 14) ? 2'b01 : 2'b10);
`ifdef BUTTON_UP_LATCH_EN
         exp = (k >= 6) && (k < 14);
`else
         exp = (k >= 6);
`endif
         check_value("rise_on_tick", button_up, exp);
      end

      // Reset mid-debounce: partial count discarded.
      step(1'b0, 1'b0, 2'b00);
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         step(1'b1, 1'b0, 2'b00);
         check_value("pre_reset_up", button_up, 1'b0);
      end
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b0, 2'b00);
         check_value("post_reset_up", button_up, k >= 6);
      end

      // Randomized bouncing buttons, random ticks, occasional resets.
      r_up = 1'b0;
      r_dn = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 5) == 0) r_up = ~r_up;
         if ($urandom_range(0, 5) == 0) r_dn = ~r_dn;
         step(r_up, r_dn, {1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0)});
         if ($urandom_range(0, 299) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_button_conditioner
